// File: rtl/alu_cmd_queue.sv
// rtl/alu_cmd_queue.sv - command FIFO and registered issue stage feeding the 8-bit ALU
// Define ALU_CMD_QUEUE_BYPASS_EN to let a command skip the FIFO when the queue is empty.
module alu_cmd_queue #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_a,
   input  logic [WIDTH-1:0]         in_b,
   input  logic [1:0]               in_opcode,
   input  logic                     stall,
   output logic [WIDTH-1:0]         alu_a,
   output logic [WIDTH-1:0]         alu_b,
   output logic [1:0]               alu_opcode,
   output logic                     issue_valid,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = 2 * WIDTH + 2;

   logic [EW-1:0]    mem_q [DEPTH];
   logic [EW-1:0]    mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [1:0]       alu_opcode_q, alu_opcode_d;
   logic             issue_valid_q, issue_valid_d;
   logic             push, pop, bypass, store;

   // Handshake flags depend on the registered count only, so in_ready never sees in_valid or stall.
   assign full        = (count_q == (AW+1)'(DEPTH));
   assign empty       = (count_q == '0);
   assign in_ready    = !full;
   assign count       = count_q;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_opcode  = alu_opcode_q;
   assign issue_valid = issue_valid_q;

   always_comb begin
      push = in_valid && in_ready;
      pop  = !empty && !stall;
`ifdef ALU_CMD_QUEUE_BYPASS_EN
      bypass = push && empty && !stall;
`else
      bypass = 1'b0;
`endif
      store         = push && !bypass;
      mem_d         = mem_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      alu_a_d       = alu_a_q;
      alu_b_d       = alu_b_q;
      alu_opcode_d  = alu_opcode_q;
      issue_valid_d = 1'b0;

      if (pop) begin
         {alu_a_d, alu_b_d, alu_opcode_d} = mem_q[rd_ptr_q];
         issue_valid_d = 1'b1;
         rd_ptr_d      = rd_ptr_q + AW'(1);
      end else if (bypass) begin
         {alu_a_d, alu_b_d, alu_opcode_d} = {in_a, in_b, in_opcode};
         issue_valid_d = 1'b1;
      end

      if (store) begin
         mem_d[wr_ptr_q] = {in_a, in_b, in_opcode};
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end

      case ({store, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (rst) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         alu_a_q       <= '0;
         alu_b_q       <= '0;
         alu_opcode_q  <= 2'b00;
         issue_valid_q <= 1'b0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         alu_a_q       <= alu_a_d;
         alu_b_q       <= alu_b_d;
         alu_opcode_q  <= alu_opcode_d;
         issue_valid_q <= issue_valid_d;
      end
   end

endmodule
